// File: rtl/fetch_ctrl.sv
// fetch_ctrl: loads a program image into instruction memory through a
// valid/ready port, then switches permanently to sequential instruction
// fetch with downstream stall and branch/jump redirect.
module fetch_ctrl #(
    parameter logic [31:0] PC_BASE_ADDR   = 32'h8002_0000,
    parameter int unsigned PROG_MAX_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    // loader port
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    // instruction memory
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_rw,
    output logic        mem_en,
    input  logic [31:0] mem_data_out,
    // decode side
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    // status
    output logic        loading,
    output logic [31:0] load_count,
    output logic        load_overflow
);

    localparam logic [0:0] ST_LOAD  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    localparam logic [31:0] MAX_WORDS = 32'(PROG_MAX_WORDS);

    logic [0:0]  state;
    logic [31:0] fetch_pc;  // next address to issue
    logic [31:0] req_pc;    // address whose data is on mem_data_out
    logic        req_valid;

    logic [31:0] load_next;
    logic        load_full;

    assign load_next = load_count + 32'd1;
    assign load_full = (load_next == MAX_WORDS);
    assign loading   = (state == ST_LOAD);

    // Memory and loader controls; everything is quiet while reset is held.
    always_comb begin
        ld_ready    = 1'b0;
        mem_en      = 1'b0;
        mem_rw      = 1'b0;
        mem_addr    = 32'd0;
        mem_data_in = 32'd0;
        if (!reset) begin
            if (state == ST_LOAD) begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_en      = 1'b1;
                    mem_addr    = {load_count[29:0], 2'b00};
                    mem_data_in = ld_data;
                end
            end else begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                // During a stall re-read the in-flight word so that its data
                // is still on mem_data_out when decode finally accepts it.
                if (stall && req_valid && !redirect_valid)
                    mem_addr = req_pc - PC_BASE_ADDR;
                else
                    mem_addr = fetch_pc - PC_BASE_ADDR;
            end
        end
    end

    // State, load bookkeeping and the two-stage fetch pipeline.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_LOAD;
            load_count    <= 32'd0;
            load_overflow <= 1'b0;
            fetch_pc      <= PC_BASE_ADDR;
            req_pc        <= PC_BASE_ADDR;
            req_valid     <= 1'b0;
            instr_out     <= 32'd0;
            instr_pc      <= PC_BASE_ADDR;
            instr_valid   <= 1'b0;
        end else if (state == ST_LOAD) begin
            if (ld_valid) begin
                if (load_count < MAX_WORDS)
                    load_count <= load_next;
                if (ld_last || load_full) begin
                    state    <= ST_FETCH;
                    fetch_pc <= PC_BASE_ADDR;
                    if (!ld_last)
                        load_overflow <= 1'b1;
                end
            end
        end else begin
            if (redirect_valid) begin
                // Flush both stages; the new stream starts at the aligned PC.
                fetch_pc    <= {redirect_pc[31:2], 2'b00};
                req_valid   <= 1'b0;
                instr_valid <= 1'b0;
            end else if (!stall) begin
                instr_out   <= mem_data_out;
                instr_pc    <= req_pc;
                instr_valid <= req_valid;
                req_pc      <= fetch_pc;
                req_valid   <= 1'b1;
                fetch_pc    <= fetch_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: load, fetch, stall, redirect, overflow, reset.
module tb_fetch_ctrl;

    localparam logic [31:0] BASE = 32'h8002_0000;
    localparam logic [31:0] W0 = 32'h2008_0005;
    localparam logic [31:0] W1 = 32'h2009_0007;
    localparam logic [31:0] W2 = 32'h0109_5020;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // DUT a: default configuration with a memory model
    logic        reset, ld_valid, ld_last, ld_ready, mem_rw, mem_en;
    logic [31:0] ld_data, mem_addr, mem_data_in, mem_data_out;
    logic        stall, redirect_valid, instr_valid, loading, load_overflow;
    logic [31:0] redirect_pc, instr_out, instr_pc, load_count;

    fetch_ctrl dut (
        .clock(clock), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rw(mem_rw), .mem_en(mem_en),
        .mem_data_out(mem_data_out),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .loading(loading), .load_count(load_count), .load_overflow(load_overflow)
    );

    // DUT b: four-word program limit
    logic        b_reset, b_ld_valid, b_ld_last, b_ld_ready, b_mem_rw, b_mem_en;
    logic [31:0] b_ld_data, b_mem_addr, b_mem_data_in, b_mem_data_out;
    logic        b_stall, b_redirect_valid, b_instr_valid, b_loading, b_load_overflow;
    logic [31:0] b_redirect_pc, b_instr_out, b_instr_pc, b_load_count;

    fetch_ctrl #(.PROG_MAX_WORDS(4)) dut_b (
        .clock(clock), .reset(b_reset),
        .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_last(b_ld_last), .ld_ready(b_ld_ready),
        .mem_addr(b_mem_addr), .mem_data_in(b_mem_data_in), .mem_rw(b_mem_rw), .mem_en(b_mem_en),
        .mem_data_out(b_mem_data_out),
        .stall(b_stall), .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .instr_out(b_instr_out), .instr_pc(b_instr_pc), .instr_valid(b_instr_valid),
        .loading(b_loading), .load_count(b_load_count), .load_overflow(b_load_overflow)
    );

    // Synchronous memory: one-cycle read latency, preloaded with a marker pattern
    logic [31:0] mem [0:1023];
    always @(posedge clock) begin
        if (mem_en) begin
            if (!mem_rw) mem[mem_addr[11:2]] <= mem_data_in;
            else         mem_data_out <= mem[mem_addr[11:2]];
        end
    end

    function automatic logic [31:0] pat(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = pat(i);
        mem_data_out = 32'd0;
        reset = 1'b1; ld_valid = 1'b0; ld_data = 32'd0; ld_last = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        b_reset = 1'b1; b_ld_valid = 1'b0; b_ld_data = 32'd0; b_ld_last = 1'b0;
        b_stall = 1'b0; b_redirect_valid = 1'b0; b_redirect_pc = 32'd0;
        b_mem_data_out = 32'd0;

        // reset state
        cyc(); cyc(); #1;
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_loading", 32'(loading), 32'd1);
        check("rst_load_count", load_count, 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_pc", instr_pc, BASE);
        check("rst_instr_out", instr_out, 32'd0);
        check("rst_overflow", 32'(load_overflow), 32'd0);

        // load three words
        reset = 1'b0; ld_valid = 1'b1; ld_data = W0; #1;
        check("ld0_ready", 32'(ld_ready), 32'd1);
        check("ld0_en", 32'(mem_en), 32'd1);
        check("ld0_rw", 32'(mem_rw), 32'd0);
        check("ld0_addr", mem_addr, 32'd0);
        check("ld0_data", mem_data_in, W0);
        cyc(); ld_data = W1; #1;
        check("ld1_count", load_count, 32'd1);
        check("ld1_addr", mem_addr, 32'd4);
        cyc(); ld_data = W2; ld_last = 1'b1; #1;
        check("ld2_addr", mem_addr, 32'd8);
        check("ld2_data", mem_data_in, W2);
        cyc(); ld_valid = 1'b0; ld_last = 1'b0; #1;
        // first FETCH cycle
        check("f0_loading", 32'(loading), 32'd0);
        check("f0_ready", 32'(ld_ready), 32'd0);
        check("f0_rw", 32'(mem_rw), 32'd1);
        check("f0_addr", mem_addr, 32'd0);
        check("f0_count", load_count, 32'd3);
        check("f0_valid", 32'(instr_valid), 32'd0);
        cyc(); #1;
        check("f1_valid", 32'(instr_valid), 32'd0);
        check("f1_addr", mem_addr, 32'd4);
        cyc(); #1;
        check("f2_valid", 32'(instr_valid), 32'd1);
        check("f2_pc", instr_pc, BASE);
        check("f2_out", instr_out, W0);

        // stall three cycles while word at +4 is presented
        cyc(); stall = 1'b1; #1;
        check("s0_pc", instr_pc, BASE + 32'd4);
        check("s0_out", instr_out, W1);
        check("s0_addr_replay", mem_addr, 32'd8);
        cyc(); #1;
        check("s1_pc", instr_pc, BASE + 32'd4);
        check("s1_valid", 32'(instr_valid), 32'd1);
        cyc(); #1;
        check("s2_pc", instr_pc, BASE + 32'd4);
        check("s2_addr_replay", mem_addr, 32'd8);
        cyc(); stall = 1'b0; #1;
        check("s3_pc", instr_pc, BASE + 32'd4);
        check("s3_out", instr_out, W1);
        cyc(); #1;
        check("s4_pc", instr_pc, BASE + 32'd8);
        check("s4_out", instr_out, W2);

        // redirect to 0x80020012
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h8002_0012; #1;
        check("r0_pc", instr_pc, BASE + 32'hC);
        check("r0_out", instr_out, pat(3));
        check("r0_addr", mem_addr, 32'h14);
        cyc(); redirect_valid = 1'b0; #1;
        check("r1_valid", 32'(instr_valid), 32'd0);
        check("r1_addr", mem_addr, 32'h10);
        cyc(); #1;
        check("r2_valid", 32'(instr_valid), 32'd0);
        cyc(); #1;
        check("r3_valid", 32'(instr_valid), 32'd1);
        check("r3_pc", instr_pc, 32'h8002_0010);
        check("r3_out", instr_out, pat(4));
        cyc();
        // redirect and stall together: redirect wins over address replay
        redirect_valid = 1'b1; redirect_pc = 32'h8002_0001; stall = 1'b1; #1;
        check("r4_pc", instr_pc, 32'h8002_0014);
        check("r4_out", instr_out, pat(5));
        check("rs_addr", mem_addr, 32'h1C);
        cyc(); redirect_valid = 1'b0; #1;
        check("rs1_valid", 32'(instr_valid), 32'd0);
        check("rs1_addr", mem_addr, 32'd0);
        cyc(); stall = 1'b0; #1;
        check("rs2_valid", 32'(instr_valid), 32'd0);
        cyc(); #1;
        check("rs3_valid", 32'(instr_valid), 32'd0);
        cyc(); #1;
        check("rs4_valid", 32'(instr_valid), 32'd1);
        check("rs4_pc", instr_pc, BASE);
        check("rs4_out", instr_out, W0);

        // reset during FETCH
        reset = 1'b1; cyc(); #1;
        check("rr_loading", 32'(loading), 32'd1);
        check("rr_valid", 32'(instr_valid), 32'd0);
        check("rr_count", load_count, 32'd0);
        check("rr_ready_held", 32'(ld_ready), 32'd0);
        reset = 1'b0; #1;
        check("rr_ready", 32'(ld_ready), 32'd1);
        check("rr_mem_en", 32'(mem_en), 32'd0);

        // overflow on the small instance
        b_reset = 1'b0; b_ld_valid = 1'b1; b_ld_data = 32'h1111_0000; #1;
        check("b_ready", 32'(b_ld_ready), 32'd1);
        cyc(); cyc(); cyc(); #1;
        check("b3_count", b_load_count, 32'd3);
        check("b3_addr", b_mem_addr, 32'd12);
        check("b3_overflow", 32'(b_load_overflow), 32'd0);
        cyc(); #1;
        check("b4_overflow", 32'(b_load_overflow), 32'd1);
        check("b4_count", b_load_count, 32'd4);
        check("b4_loading", 32'(b_loading), 32'd0);
        check("b4_ready", 32'(b_ld_ready), 32'd0);
        check("b4_rw", 32'(b_mem_rw), 32'd1);
        cyc(); #1;
        check("b5_count", b_load_count, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
